// File: rtl/hack_rom_uploader.sv
// hack_rom_uploader: serves HPS upload byte reads (ioctl_rd/ioctl_addr) from a
// 16-bit program memory through its second read port. The last fetched word
// is cached, so the second byte of a word never costs a memory read.
//
// Optional feature: define HACK_UPLOAD_CHECKSUM_EN to accumulate a 16-bit
// running sum of every word fetched from memory during the current upload
// session. Without the macro, checksum is tied to 0.
//
// Ports:
//   clk_sys       system clock, all state on rising edge
//   reset_n       asynchronous active-low reset
//   ioctl_upload  high for the whole upload session
//   ioctl_rd      one-cycle byte request strobe
//   ioctl_addr    byte address of the request
//   ioctl_din     returned byte (big-endian within each word)
//   ioctl_wait    high while the requested byte is not yet valid
//   mem_addr      word address to the memory read port
//   mem_rd        one-cycle read strobe (diagnostic only)
//   mem_q         memory read data, one cycle after mem_addr
//   checksum      running word sum of the current session
module hack_rom_uploader #(
    parameter int unsigned AW = 15  // up to 24: ioctl_addr carries a 24-bit word address
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [15:0]   mem_q,
    output logic [15:0]   checksum
);

    typedef enum logic [1:0] {StIdle, StFetch, StCapture} state_e;

    state_e        state_q, state_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          cache_valid_q, cache_valid_d;
    logic [AW-1:0] cache_addr_q, cache_addr_d;
    logic [15:0]   cache_data_q, cache_data_d;
    logic          byte_sel_q, byte_sel_d;

    logic [23:0]   req_word;
    logic [AW-1:0] req_word_aw;
    logic          req_in_range;
    logic          req_hit;

    assign req_word     = ioctl_addr[24:1];
    assign req_word_aw  = req_word[AW-1:0];
    assign req_in_range = (req_word >> AW) == 24'd0;
    assign req_hit      = cache_valid_q && (cache_addr_q == req_word_aw);

    always_comb begin
        state_d       = state_q;
        din_d         = din_q;
        wait_d        = wait_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = mem_rd_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        byte_sel_d    = byte_sel_q;

        if (!ioctl_upload) begin
            // Outside a session: abort anything in flight, keep ioctl_din.
            state_d       = StIdle;
            wait_d        = 1'b0;
            mem_rd_d      = 1'b0;
            cache_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ioctl_rd) begin
                        if (!req_in_range) begin
                            din_d = 8'h00;
                        end else if (req_hit) begin
                            din_d = ioctl_addr[0] ? cache_data_q[7:0] : cache_data_q[15:8];
                        end else begin
                            mem_addr_d = req_word_aw;
                            mem_rd_d   = 1'b1;
                            wait_d     = 1'b1;
                            byte_sel_d = ioctl_addr[0];
                            state_d    = StFetch;
                        end
                    end
                end
                StFetch: begin
                    // Memory samples mem_addr on this edge; data is ready next cycle.
                    mem_rd_d = 1'b0;
                    state_d  = StCapture;
                end
                StCapture: begin
                    cache_data_d  = mem_q;
                    cache_addr_d  = mem_addr_q;
                    cache_valid_d = 1'b1;
                    din_d         = byte_sel_q ? mem_q[7:0] : mem_q[15:8];
                    wait_d        = 1'b0;
                    state_d       = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            din_q         <= 8'h00;
            wait_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= 16'h0000;
            byte_sel_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            din_q         <= din_d;
            wait_q        <= wait_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            byte_sel_q    <= byte_sel_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;

`ifdef HACK_UPLOAD_CHECKSUM_EN
    logic        upload_q;
    logic [15:0] checksum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            upload_q   <= 1'b0;
            checksum_q <= 16'h0000;
        end else begin
            upload_q <= ioctl_upload;
            if (ioctl_upload && !upload_q) begin
                checksum_q <= 16'h0000;
            end else if (ioctl_upload && (state_q == StCapture)) begin
                checksum_q <= checksum_q + mem_q;
            end
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_hack_rom_uploader.sv
// Testbench for hack_rom_uploader: directed scenarios plus randomized reads,
// predicted by a word-cache reference model and checked by a scoreboard
// monitor that measures each response (byte, wait length, read strobes).
module tb_hack_rom_uploader;

    localparam int unsigned AW = 15;
    localparam int          NW = 1 << AW;
`ifdef HACK_UPLOAD_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic          clk_sys      = 1'b0;
    logic          reset_n      = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd     = 1'b0;
    logic [24:0]   ioctl_addr   = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [15:0]   mem_q;
    logic [15:0]   checksum;

    always #5 clk_sys = ~clk_sys;

    hack_rom_uploader #(.AW(AW)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_q        (mem_q),
        .checksum     (checksum)
    );

    // Program memory: synchronous read port, reads every cycle.
    logic [15:0] mem [NW];
    always @(posedge clk_sys) mem_q <= mem[mem_addr];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_upload = 1'b0;
    bit          m_cv     = 1'b0;
    int          m_cw     = 0;
    logic [15:0] m_cd     = 16'h0000;
    logic [7:0]  m_din    = 8'h00;
    logic [15:0] m_csum   = 16'h0000;

    typedef struct {
        logic [7:0]  din;
        int          waits;
        int          rds;
        logic [15:0] csum;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   issued   = 0;
    int   answered = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predicts the response from the model, queues it, then pulses ioctl_rd.
    task automatic issue(input logic [24:0] addr, input string name);
        exp_t e;
        int   w;
        @(negedge clk_sys);
        w       = int'(addr >> 1);
        e.waits = 0;
        e.rds   = 0;
        e.name  = name;
        if (m_upload) begin
            if (w >= NW) begin
                m_din = 8'h00;
            end else if (m_cv && m_cw == w) begin
                m_din = addr[0] ? m_cd[7:0] : m_cd[15:8];
            end else begin
                m_cd  = mem[w];
                m_cw  = w;
                m_cv  = 1'b1;
                m_din = addr[0] ? m_cd[7:0] : m_cd[15:8];
                if (CsumEn) m_csum = m_csum + m_cd;
                e.waits = 2;
                e.rds   = 1;
            end
        end
        e.din  = m_din;
        e.csum = m_csum;
        exp_q.push_back(e);
        issued++;
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && answered < issued; i++) @(negedge clk_sys);
        if (answered < issued) begin
            checks++;
            errors++;
            $display("FAIL response_timeout: got %0d answers, expected %0d", answered, issued);
            answered = issued;
            exp_q.delete();
        end
    endtask

    task automatic read(input logic [24:0] addr, input string name);
        issue(addr, name);
        wait_done();
    endtask

    task automatic set_upload(input bit v);
        @(negedge clk_sys);
        ioctl_upload = v;
        if (v && !m_upload) m_csum = 16'h0000;
        m_cv     = 1'b0;
        m_upload = v;
    endtask

    // Scoreboard monitor: the queued request is presented at the next rising edge.
    initial begin
        exp_t e;
        int   n;
        int   r;
        forever begin
            @(posedge clk_sys);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                n = 0;
                r = 0;
                if (mem_rd) r++;
                while (ioctl_wait && n < 10) begin
                    n++;
                    @(posedge clk_sys);
                    #1;
                    if (mem_rd) r++;
                end
                chk({e.name, " din"}, 32'(ioctl_din), 32'(e.din));
                chk({e.name, " wait_cycles"}, n, e.waits);
                chk({e.name, " mem_rd_pulses"}, r, e.rds);
                chk({e.name, " checksum"}, 32'(checksum), 32'(e.csum));
                answered++;
            end
        end
    end

    initial begin
        logic [24:0] a;
        int          sel;

        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);

        // Reset state.
        repeat (2) @(posedge clk_sys);
        #1;
        chk("reset din", 32'(ioctl_din), 0);
        chk("reset wait", 32'(ioctl_wait), 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset mem_rd", 32'(mem_rd), 0);
        chk("reset checksum", 32'(checksum), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Session A: miss, hit, out of range.
        mem[0] = 16'hEA10;
        set_upload(1'b1);
        read(25'd0, "word0_hi_miss");
        read(25'd1, "word0_lo_hit");
        read(25'h10000, "out_of_range");

        // A second strobe during FETCH is ignored and not queued.
        issue(25'd4, "rd_during_fetch");
        ioctl_addr = 25'd8;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        wait_done();
        read(25'd9, "ignored_word_misses");

        // Dropping upload mid-fetch clears wait on the next edge and keeps din.
        @(negedge clk_sys);
        ioctl_addr = 25'd12;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("drop fetch_started", 32'(ioctl_wait), 1);
        ioctl_upload = 1'b0;
        m_upload     = 1'b0;
        m_cv         = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("drop wait", 32'(ioctl_wait), 0);
        chk("drop mem_rd", 32'(mem_rd), 0);
        chk("drop din_held", 32'(ioctl_din), 32'(m_din));

        read(25'd0, "rd_while_upload_low");

        // Session B: checksum wrap.
        mem[0] = 16'hFFFF;
        mem[1] = 16'h0002;
        set_upload(1'b1);
        for (int i = 0; i < 4; i++) read(25'(i), "csum_bytes");
        chk("csum_wrap", 32'(checksum), CsumEn ? 32'h0001 : 32'h0000);

        // Reset mid-fetch.
        @(negedge clk_sys);
        ioctl_addr = 25'd20;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("rst fetch_started", 32'(ioctl_wait), 1);
        reset_n = 1'b0;
        #1;
        chk("rst din", 32'(ioctl_din), 0);
        chk("rst wait", 32'(ioctl_wait), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst checksum", 32'(checksum), 0);
        m_din  = 8'h00;
        m_cv   = 1'b0;
        m_csum = 16'h0000;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        reset_n  = 1'b1;
        read(25'd1, "after_reset_miss");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 39));
            if (sel == 0) begin
                set_upload(1'b0);
                for (int j = 0; j < 4; j++) mem[$urandom_range(0, 7)] = 16'($urandom);
                set_upload(1'b1);
            end else if (sel == 1) begin
                set_upload(1'b0);
                read(25'($urandom_range(0, 15)), "rand_upload_low");
                set_upload(1'b1);
            end else begin
                if (sel < 5)      a = 25'($urandom_range(32'h10000, 32'h1FFFFFF));
                else if (sel < 8) a = 25'($urandom_range(0, 32'hFFFF));
                else              a = 25'($urandom_range(0, 15));
                read(a, "rand_read");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_rom_uploader.md
HACK_ROM_UPLOADER -- requirements
Module: hack_rom_uploader

Interface
REQ-001 Parameter AW, default 15, word-address width of the program memory.
REQ-002 clk_sys  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ioctl_upload  input  1  high for the whole HPS upload session.
REQ-005 ioctl_rd  input  1  one-cycle pulse; HPS requests the byte at ioctl_addr.
REQ-006 ioctl_addr  input  25  byte address of the requested byte.
REQ-007 ioctl_din  output  8  byte returned to HPS.
REQ-008 ioctl_wait  output  1  high while the requested byte is not yet valid.
REQ-009 mem_addr  output  AW  word address to the memory's second read port.
REQ-010 mem_rd  output  1  one-cycle read strobe; diagnostic only, memory reads every cycle.
REQ-011 mem_q  input  16  memory read data, valid one clk_sys cycle after mem_addr is registered.
REQ-012 checksum  output  16  running word sum of the current session.

Function
REQ-013 Byte mapping: word = ioctl_addr>>1; ioctl_addr[0]=0 selects mem_q[15:8], =1 selects mem_q[7:0] (big-endian, matching the loader's high-byte-first packing).
REQ-014 States: IDLE, FETCH, CAPTURE; the state is IDLE whenever ioctl_upload is low.
REQ-015 Word cache: last fetched word plus its word address plus a valid bit.
REQ-016 Hit (ioctl_rd in IDLE, cache valid, same word): ioctl_din updated at that edge; ioctl_wait stays 0; no fetch.
REQ-017 Miss in IDLE: at edge k, mem_addr<=word, mem_rd<=1, ioctl_wait<=1, go to FETCH.
REQ-018 FETCH to CAPTURE at edge k+1; mem_rd<=0.
REQ-019 CAPTURE at edge k+2: latch mem_q into the cache, drive the selected byte on ioctl_din, ioctl_wait<=0, return to IDLE; ioctl_wait is high for exactly 2 cycles.
REQ-020 Out of range (word >= 2^AW): ioctl_din<=8'h00 at edge k, no fetch, ioctl_wait stays 0, cache unchanged.
REQ-021 ioctl_rd while in FETCH or CAPTURE is ignored; it neither queues nor alters the outstanding request.
REQ-022 ioctl_upload falling at any state: go to IDLE, ioctl_wait<=0, mem_rd<=0, cache invalid; ioctl_din holds its value.
REQ-023 ioctl_upload rising: cache invalid and checksum cleared to 0.
REQ-024 ioctl_rd while ioctl_upload is low is ignored.

Reset
REQ-025 reset_n low asynchronously forces: state IDLE, ioctl_din=0, ioctl_wait=0, mem_addr=0, mem_rd=0, cache invalid, checksum=0.
REQ-026 Reset takes effect mid-fetch; the aborted request produces no ioctl_din update.
REQ-027 After reset_n deasserts, the first ioctl_rd is always treated as a miss.

Configuration
REQ-028 Macro HACK_UPLOAD_CHECKSUM_EN defined: in CAPTURE, checksum <= checksum + mem_q, 16-bit wrap-around; hits and out-of-range reads do not add.
REQ-029 Macro not defined: the checksum port still exists and is constant 0; no adder is synthesized.

Verification
REQ-030 Memory word0=16'hEA10, upload high, ioctl_rd at addr 0 -> ioctl_wait high exactly 2 cycles, ioctl_din=8'hEA, mem_rd one pulse.
REQ-031 Then ioctl_rd at addr 1 -> ioctl_din=8'h10 on the next edge, ioctl_wait never high, no mem_rd.
REQ-032 ioctl_rd at addr 25'h10000 (AW=15) -> ioctl_din=8'h00, no wait, no mem_rd.
REQ-033 reset_n low in FETCH -> all outputs 0 immediately; next ioctl_rd at addr 1 misses and fetches.
REQ-034 With macro defined, word0=16'hFFFF and word1=16'h0002, read bytes 0..3 -> checksum=16'h0001; without macro, checksum=0.
REQ-035 Second ioctl_rd pulse during FETCH -> ignored, only the first byte is returned; dropping ioctl_upload mid-fetch -> ioctl_wait=0 on the next edge.
